// File: rtl/multi_channel_counter.sv
// Bank of CHANNELS up/down counters; one channel (Slt) steps, loads or wraps per cycle.
// Optional sticky overflow flags are built when MULTI_CHANNEL_COUNTER_STICKY_EN is defined.
module multi_channel_counter #(
    parameter int WIDTH    = 64,
    parameter int CHANNELS = 2,
    parameter int SEL_W    = 1,
    parameter int SATURATE = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      En,
    input  logic [SEL_W-1:0]          Slt,
    input  logic                      Dir,
    input  logic                      Load,
    input  logic [WIDTH-1:0]          Load_val,
    input  logic                      Clr_all,
    output logic [CHANNELS*WIDTH-1:0] Output,
    output logic [WIDTH-1:0]          Sel_out,
    output logic [CHANNELS-1:0]       Wrap
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
    ,
    output logic [CHANNELS-1:0]       Ovf_sticky
`endif
);

    logic [WIDTH-1:0] count [CHANNELS];
    logic             sel_valid;
    logic [WIDTH-1:0] sel_val;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_val;
    logic             at_limit;

    // The extra bit lets CHANNELS == 2**SEL_W be represented in the compare.
    assign sel_valid = ({1'b0, Slt} < (SEL_W+1)'(CHANNELS));

    always_comb begin
        sel_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (sel_valid && Slt == SEL_W'(i)) begin
                sel_val = count[i];
            end
        end
    end

    always_comb begin
        Output = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            Output[i*WIDTH +: WIDTH] = count[i];
        end
    end

    assign Sel_out  = sel_val;
    assign at_limit = Dir ? (sel_val == '0) : (sel_val == '1);
    assign step_val = Dir ? sel_val - WIDTH'(1) : sel_val + WIDTH'(1);
    // In saturate mode a step past the limit leaves the value in place.
    assign next_val = (SATURATE != 0 && at_limit) ? sel_val : step_val;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            Wrap <= '0;
        end else if (Clr_all) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count[i] <= '0;
            end
            Wrap <= '0;
        end else begin
            Wrap <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_valid && Slt == SEL_W'(i)) begin
                    if (Load) begin
                        count[i] <= Load_val;
                    end else if (En) begin
                        count[i] <= next_val;
                        Wrap[i]  <= at_limit;
                    end
                end
            end
        end
    end

`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            Ovf_sticky <= '0;
        end else if (Clr_all) begin
            Ovf_sticky <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (sel_valid && Slt == SEL_W'(i) && !Load && En && at_limit) begin
                    Ovf_sticky[i] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_multi_channel_counter.sv
// Randomised bench for multi_channel_counter: four parameterisations share one stimulus
// stream and are compared every cycle against an arithmetic model, plus literal scenario checks.
module tb_multi_channel_counter;

    logic        Clk = 1'b0;
    logic        Reset, En, Dir, Load, Clr_all;
    logic        slt1;
    logic [1:0]  slt2;
    logic [7:0]  lv8;
    logic [63:0] lv64;
    logic        check_en = 1'b0;
    int          checks = 0;
    int          passes = 0;

    logic [127:0] out0;  logic [63:0] sel0;  logic [1:0] wrap0;
    logic [31:0]  out1;  logic [7:0]  sel1;  logic [3:0] wrap1;
    logic [31:0]  out2;  logic [7:0]  sel2;  logic [3:0] wrap2;
    logic [23:0]  out3;  logic [7:0]  sel3;  logic [2:0] wrap3;
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
    logic [1:0] stk0;  logic [3:0] stk1;  logic [3:0] stk2;  logic [2:0] stk3;
`endif

    always #5 Clk = ~Clk;

    multi_channel_counter u0 (
        .Clk(Clk), .Reset(Reset), .En(En), .Slt(slt1), .Dir(Dir), .Load(Load),
        .Load_val(lv64), .Clr_all(Clr_all), .Output(out0), .Sel_out(sel0), .Wrap(wrap0)
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
        , .Ovf_sticky(stk0)
`endif
    );

    multi_channel_counter #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .SATURATE(0)) u1 (
        .Clk(Clk), .Reset(Reset), .En(En), .Slt(slt2), .Dir(Dir), .Load(Load),
        .Load_val(lv8), .Clr_all(Clr_all), .Output(out1), .Sel_out(sel1), .Wrap(wrap1)
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
        , .Ovf_sticky(stk1)
`endif
    );

    multi_channel_counter #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .SATURATE(1)) u2 (
        .Clk(Clk), .Reset(Reset), .En(En), .Slt(slt2), .Dir(Dir), .Load(Load),
        .Load_val(lv8), .Clr_all(Clr_all), .Output(out2), .Sel_out(sel2), .Wrap(wrap2)
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
        , .Ovf_sticky(stk2)
`endif
    );

    multi_channel_counter #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .SATURATE(0)) u3 (
        .Clk(Clk), .Reset(Reset), .En(En), .Slt(slt2), .Dir(Dir), .Load(Load),
        .Load_val(lv8), .Clr_all(Clr_all), .Output(out3), .Sel_out(sel3), .Wrap(wrap3)
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
        , .Ovf_sticky(stk3)
`endif
    );

    // Model: per instance, an array of plain integer counter values plus wrap/sticky bits.
    int          wid [4] = '{64, 8, 8, 8};
    int          chn [4] = '{2, 4, 4, 3};
    int          sat [4] = '{0, 0, 1, 0};
    logic [63:0] mc [4][4];
    logic [3:0]  mw [4];
    logic [3:0]  ms [4];

    function automatic logic [63:0] maxv(input int w);
        return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    endfunction

    always @(posedge Clk or negedge Reset) begin
        int s;
        logic [63:0] lv, mx;
        for (int i = 0; i < 4; i++) begin
            if (!Reset || Clr_all) begin
                for (int c = 0; c < 4; c++) mc[i][c] = 64'd0;
                mw[i] = 4'd0;
                ms[i] = 4'd0;
            end else begin
                s  = (i == 0) ? int'(slt1) : int'(slt2);
                lv = (i == 0) ? lv64 : {56'd0, lv8};
                mx = maxv(wid[i]);
                mw[i] = 4'd0;
                if (s < chn[i]) begin
                    if (Load) begin
                        mc[i][s] = lv;
                    end else if (En) begin
                        if (!Dir && mc[i][s] == mx) begin
                            mw[i][s] = 1'b1;
                            ms[i][s] = 1'b1;
                            mc[i][s] = (sat[i] != 0) ? mx : 64'd0;
                        end else if (Dir && mc[i][s] == 64'd0) begin
                            mw[i][s] = 1'b1;
                            ms[i][s] = 1'b1;
                            mc[i][s] = (sat[i] != 0) ? 64'd0 : mx;
                        end else begin
                            mc[i][s] = Dir ? mc[i][s] - 64'd1 : mc[i][s] + 64'd1;
                        end
                    end
                end
            end
        end
    end

    function automatic logic [255:0] exp_out(input int i);
        logic [255:0] v = '0;
        for (int c = 0; c < chn[i]; c++) v |= 256'(mc[i][c]) << (c * wid[i]);
        return v;
    endfunction

    function automatic logic [63:0] exp_sel(input int i);
        int s = (i == 0) ? int'(slt1) : int'(slt2);
        return (s < chn[i]) ? mc[i][s] : 64'd0;
    endfunction

    function automatic logic [255:0] dut_out(input int i);
        case (i)
            0: return 256'(out0);
            1: return 256'(out1);
            2: return 256'(out2);
            default: return 256'(out3);
        endcase
    endfunction

    function automatic logic [63:0] dut_sel(input int i);
        case (i)
            0: return sel0;
            1: return 64'(sel1);
            2: return 64'(sel2);
            default: return 64'(sel3);
        endcase
    endfunction

    function automatic logic [3:0] dut_wrap(input int i);
        case (i)
            0: return 4'(wrap0);
            1: return wrap1;
            2: return wrap2;
            default: return 4'(wrap3);
        endcase
    endfunction

`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
    function automatic logic [3:0] dut_stk(input int i);
        case (i)
            0: return 4'(stk0);
            1: return stk1;
            2: return stk2;
            default: return 4'(stk3);
        endcase
    endfunction
`endif

    task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Every cycle, away from the rising edge, every instance must match the model.
    always @(negedge Clk) begin
        if (check_en) begin
            for (int i = 0; i < 4; i++) begin
                checkOutput($sformatf("model_out%0d", i), dut_out(i), exp_out(i));
                checkOutput($sformatf("model_sel%0d", i), 256'(dut_sel(i)), 256'(exp_sel(i)));
                checkOutput($sformatf("model_wrap%0d", i), 256'(dut_wrap(i)), 256'(mw[i]));
`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
                checkOutput($sformatf("model_stk%0d", i), 256'(dut_stk(i)), 256'(ms[i]));
`endif
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic dir, input logic load, input logic clr,
                                 input logic [1:0] s2, input logic s1, input logic [7:0] l8,
                                 input logic [63:0] l64);
        En = en; Dir = dir; Load = load; Clr_all = clr;
        slt2 = s2; slt1 = s1; lv8 = l8; lv64 = l64;
    endtask

    task automatic cycle();
        @(posedge Clk);
        @(negedge Clk);
        #1;
    endtask

    initial begin
        Reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 2'd0, 1'b0, 8'h00, 64'd0);
        #7;
        checkOutput("reset_out0", 256'(out0), 256'd0);
        checkOutput("reset_sel0", 256'(sel0), 256'd0);
        checkOutput("reset_wrap1", 256'(wrap1), 256'd0);
        #3;
        Reset = 1'b1;
        check_en = 1'b1;

        applyStimulus(1, 0, 0, 0, 2'd1, 1'b1, 8'h00, 64'd0);
        repeat (5) cycle();
        checkOutput("s1_ch1", 256'(out0[127:64]), 256'd5);
        checkOutput("s1_ch0", 256'(out0[63:0]), 256'd0);
        checkOutput("s1_sel", 256'(sel0), 256'd5);

        applyStimulus(0, 0, 1, 0, 2'd2, 1'b0, 8'hFE, 64'd0);
        cycle();
        applyStimulus(1, 0, 0, 0, 2'd2, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("s2_ff", 256'(out1[23:16]), 256'hFF);
        checkOutput("s2_nowrap", 256'(wrap1), 256'd0);
        cycle();
        checkOutput("s2_00", 256'(out1[23:16]), 256'h00);
        checkOutput("s2_wrap", 256'(wrap1), 256'b0100);
        applyStimulus(0, 0, 0, 0, 2'd2, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("s2_wrap_gone", 256'(wrap1), 256'd0);

        applyStimulus(0, 0, 1, 0, 2'd3, 1'b0, 8'h01, 64'd0);
        cycle();
        applyStimulus(1, 1, 0, 0, 2'd3, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("s3_v1", 256'(out2[31:24]), 256'h00);
        checkOutput("s3_w1", 256'(wrap2[3]), 256'd0);
        cycle();
        checkOutput("s3_v2", 256'(out2[31:24]), 256'h00);
        checkOutput("s3_w2", 256'(wrap2[3]), 256'd1);
        cycle();
        checkOutput("s3_v3", 256'(out2[31:24]), 256'h00);
        checkOutput("s3_w3", 256'(wrap2[3]), 256'd1);
        applyStimulus(0, 0, 0, 0, 2'd3, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("s3_w_gone", 256'(wrap2[3]), 256'd0);

        for (int k = 1; k < 4; k++) begin
            applyStimulus(0, 0, 1, 0, 2'(k), 1'b0, 8'(8'h11 * (k + 1)), 64'd0);
            cycle();
        end
        applyStimulus(0, 0, 1, 0, 2'd0, 1'b0, 8'h00, 64'd0);
        cycle();
        applyStimulus(1, 1, 0, 0, 2'd0, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("s4_pre", 256'(out1), 256'h443322FF);
        checkOutput("s4_pre_wrap", 256'(wrap1), 256'b0001);
        applyStimulus(1, 0, 1, 1, 2'd1, 1'b1, 8'h77, 64'd7);
        cycle();
        checkOutput("s4_clr", 256'(out1), 256'd0);
        checkOutput("s4_clr_wrap", 256'(wrap1), 256'd0);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, 1, 0, 2'(k), 1'b0, 8'(8'h11 * (k + 1)), 64'd0);
            cycle();
        end
        applyStimulus(1, 0, 1, 0, 2'd3, 1'b0, 8'h99, 64'd0);
        repeat (4) begin
            cycle();
            checkOutput("s5_hold", 256'(out3), 256'h332211);
            checkOutput("s5_sel", 256'(sel3), 256'd0);
            checkOutput("s5_wrap", 256'(wrap3), 256'd0);
        end

        repeat (400) begin
            logic [7:0]  l8;
            logic [63:0] l64;
            case ($urandom_range(0, 4))
                0: begin l8 = 8'hFF; l64 = 64'hFFFF_FFFF_FFFF_FFFF; end
                1: begin l8 = 8'h00; l64 = 64'd0; end
                2: begin l8 = 8'hFE; l64 = 64'hFFFF_FFFF_FFFF_FFFE; end
                3: begin l8 = 8'h01; l64 = 64'd1; end
                default: begin l8 = 8'($urandom); l64 = {32'($urandom), 32'($urandom)}; end
            endcase
            applyStimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          $urandom_range(0, 4) == 0, $urandom_range(0, 24) == 0,
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), l8, l64);
            cycle();
        end

`ifdef MULTI_CHANNEL_COUNTER_STICKY_EN
        applyStimulus(0, 0, 0, 1, 2'd0, 1'b0, 8'h00, 64'd0);
        cycle();
        applyStimulus(0, 0, 1, 0, 2'd0, 1'b0, 8'hFF, 64'd0);
        cycle();
        applyStimulus(1, 0, 0, 0, 2'd0, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("stk_set", 256'(stk1[0]), 256'd1);
        applyStimulus(0, 0, 1, 0, 2'd0, 1'b0, 8'h10, 64'd0);
        cycle();
        checkOutput("stk_load_keeps", 256'(stk1[0]), 256'd1);
        applyStimulus(0, 0, 0, 1, 2'd0, 1'b0, 8'h00, 64'd0);
        cycle();
        checkOutput("stk_clr", 256'(stk1), 256'd0);
`endif

        applyStimulus(0, 0, 1, 0, 2'd1, 1'b1, 8'h5A, 64'd9);
        cycle();
        applyStimulus(1, 0, 0, 0, 2'd1, 1'b1, 8'h00, 64'd0);
        cycle();
        checkOutput("mid_pre", 256'(out1[15:8]), 256'h5B);
        Reset = 1'b0;
        #1;
        checkOutput("mid_rst_out1", 256'(out1), 256'd0);
        checkOutput("mid_rst_out0", 256'(out0), 256'd0);
        cycle();
        Reset = 1'b1;
        cycle();
        checkOutput("mid_resume", 256'(out1[15:8]), 256'h01);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
